// File: rtl/control_unit_multicycle_if.sv
// Control bundle between the multicycle control unit and its datapath/memory.
// MULDIV_EN adds the mdu_start/mdu_done handshake.
interface control_unit_multicycle_if #(
    parameter int unsigned ALUOP_W = 4
);
    logic [6:0]         Opcode;
    logic [2:0]         Funct3;
    logic [6:0]         Funct7;
    logic [1:0]         Comp;
    logic               mem_ready;
    logic               PCWrite;
    logic               AddrSrc;
    logic               IRWrite;
    logic               MemRead;
    logic               MemWrite;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         PCSrc;
    logic               RegWrite;
    logic [2:0]         WritebackSrc;
    logic               instr_done;
    logic               illegal;
    logic               bus_err;
`ifdef MULDIV_EN
    logic               mdu_start;
    logic               mdu_done;
`endif

    modport master (
        input  Opcode, Funct3, Funct7, Comp, mem_ready,
`ifdef MULDIV_EN
        input  mdu_done,
        output mdu_start,
`endif
        output PCWrite, AddrSrc, IRWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB,
        output ALUOp, PCSrc, RegWrite, WritebackSrc, instr_done, illegal, bus_err
    );

    modport slave (
        output Opcode, Funct3, Funct7, Comp, mem_ready,
`ifdef MULDIV_EN
        output mdu_done,
        input  mdu_start,
`endif
        input  PCWrite, AddrSrc, IRWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB,
        input  ALUOp, PCSrc, RegWrite, WritebackSrc, instr_done, illegal, bus_err
    );
endinterface

// File: rtl/control_unit_multicycle.sv
// Multicycle RV32I control FSM with memory-ready watchdog and sticky halt flags.
// Optional MULDIV_EN adds an EXEC_M state handshaking with an external MDU.
module control_unit_multicycle #(
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    control_unit_multicycle_if.master bus
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA  = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_M, S_ALU_WB, S_MDU_WB,
        S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL,
        S_JALR_ADDR, S_JALR_WB, S_LUI, S_AUIPC, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wcnt_q;
    logic               illegal_q, bus_err_q;
    logic               set_ill, set_berr, wait_st, timeout_c, count_en_c, taken_c;
    logic               pc_write_c, addr_src_c, ir_write_c, mem_read_c, mem_write_c;
    logic               reg_write_c, done_c;
    logic [1:0]         alu_a_c, alu_b_c, pc_src_c;
    logic [3:0]         alu_op_c;
    logic [2:0]         wb_src_c;
`ifdef MULDIV_EN
    logic               m_started_q, mdu_start_c;
`endif

    // Funct7[5] picks SUB only for R-type; it picks SRA for both R and I shifts.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7b5,
                                            input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign wait_st    = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timeout_c  = (MEM_TIMEOUT != 0) && (wcnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign count_en_c = wait_st && !bus.mem_ready && (MEM_TIMEOUT != 0);
    // Branch condition bit, inverted by Funct3[0] for BNE/BGE/BGEU.
    assign taken_c    = (bus.Funct3[2] ? bus.Comp[1] : bus.Comp[0]) ^ bus.Funct3[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wcnt_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (state_d != state_q) wcnt_q <= '0;
            else if (count_en_c)    wcnt_q <= wcnt_q + CNT_W'(1);
            illegal_q <= illegal_q | set_ill;
            bus_err_q <= bus_err_q | set_berr;
        end
    end

`ifdef MULDIV_EN
    // High from the second EXEC_M cycle on, so mdu_start fires once per entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) m_started_q <= 1'b0;
        else      m_started_q <= (state_q == S_EXEC_M) && (state_d == S_EXEC_M);
    end
`endif

    always_comb begin
        state_d     = state_q;
        set_ill     = 1'b0;
        set_berr    = 1'b0;
        pc_write_c  = 1'b0;
        addr_src_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        alu_a_c     = 2'd0;
        alu_b_c     = 2'd0;
        alu_op_c    = ALU_ADD;
        pc_src_c    = 2'd0;
        reg_write_c = 1'b0;
        wb_src_c    = 3'd0;
        done_c      = 1'b0;
`ifdef MULDIV_EN
        mdu_start_c = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_b_c    = 2'd2;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_c) begin
                    set_berr = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_DECODE: begin
                alu_a_c = 2'd1;
                alu_b_c = 2'd1;
                case (bus.Opcode)
                    OP_R: begin
                        if (bus.Funct7 == F7_MULDIV) begin
`ifdef MULDIV_EN
                            state_d = S_EXEC_M;
`else
                            state_d = S_HALT;
                            set_ill = 1'b1;
`endif
                        end else begin
                            state_d = S_EXEC_R;
                        end
                    end
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH: begin
                        if (bus.Funct3[2:1] == 2'b01) begin
                            state_d = S_HALT;
                            set_ill = 1'b1;
                        end else begin
                            state_d = S_BRANCH;
                        end
                    end
                    OP_JAL:   state_d = S_JAL;
                    OP_JALR:  state_d = S_JALR_ADDR;
                    OP_LUI:   state_d = S_LUI;
                    OP_AUIPC: state_d = S_AUIPC;
                    default: begin
                        state_d = S_HALT;
                        set_ill = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_a_c  = 2'd2;
                alu_op_c = arith_op(bus.Funct3, bus.Funct7[5], 1'b1);
                state_d  = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_a_c  = 2'd2;
                alu_b_c  = 2'd1;
                alu_op_c = arith_op(bus.Funct3, bus.Funct7[5], 1'b0);
                state_d  = S_ALU_WB;
            end
`ifdef MULDIV_EN
            S_EXEC_M: begin
                mdu_start_c = !m_started_q;
                if (bus.mdu_done) state_d = S_MDU_WB;
            end
            S_MDU_WB: begin
                reg_write_c = 1'b1;
                wb_src_c    = 3'd5;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
`endif
            S_ALU_WB, S_AUIPC: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_a_c = 2'd2;
                alu_b_c = 2'd1;
                state_d = bus.Opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_c = 1'b1;
                addr_src_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_c) begin
                    set_berr = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_MEM_WB: begin
                reg_write_c = 1'b1;
                wb_src_c    = 3'd1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_c = 1'b1;
                addr_src_c  = 1'b1;
                if (bus.mem_ready) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout_c) begin
                    set_berr = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_BRANCH: begin
                alu_a_c    = 2'd2;
                alu_op_c   = !bus.Funct3[2] ? ALU_SUB : (bus.Funct3[1] ? ALU_SLTU : ALU_SLT);
                pc_write_c = taken_c;
                pc_src_c   = taken_c ? 2'd1 : 2'd0;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR_ADDR: begin
                alu_a_c = 2'd2;
                alu_b_c = 2'd1;
                state_d = S_JALR_WB;
            end
            S_JAL, S_JALR_WB: begin
                reg_write_c = 1'b1;
                wb_src_c    = 3'd2;
                pc_write_c  = 1'b1;
                pc_src_c    = 2'd1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_LUI: begin
                reg_write_c = 1'b1;
                wb_src_c    = 3'd3;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Reset forces every control output low, even though the state reads FETCH.
    assign bus.PCWrite      = rst & pc_write_c;
    assign bus.AddrSrc      = rst & addr_src_c;
    assign bus.IRWrite      = rst & ir_write_c;
    assign bus.MemRead      = rst & mem_read_c;
    assign bus.MemWrite     = rst & mem_write_c;
    assign bus.ALUSrcA      = rst ? alu_a_c : 2'd0;
    assign bus.ALUSrcB      = rst ? alu_b_c : 2'd0;
    assign bus.ALUOp        = rst ? ALUOP_W'(alu_op_c) : '0;
    assign bus.PCSrc        = rst ? pc_src_c : 2'd0;
    assign bus.RegWrite     = rst & reg_write_c;
    assign bus.WritebackSrc = rst ? wb_src_c : 3'd0;
    assign bus.instr_done   = rst & done_c;
    assign bus.illegal      = illegal_q;
    assign bus.bus_err      = bus_err_q;
`ifdef MULDIV_EN
    assign bus.mdu_start    = rst & mdu_start_c;
`endif
endmodule

// File: tb/tb_control_unit_multicycle.sv
// Directed-vector bench for control_unit_multicycle (default build, MEM_TIMEOUT=16).
module tb_control_unit_multicycle;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    control_unit_multicycle_if #(.ALUOP_W(4)) bus ();

    control_unit_multicycle #(.ALUOP_W(4), .MEM_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Packs {PCWrite,AddrSrc,IRWrite,MemRead,MemWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,RegWrite,WritebackSrc,instr_done}
    function automatic logic [19:0] ex(input int pcw, input int adr, input int irw, input int mr,
                                       input int mw, input int a, input int b, input int op,
                                       input int ps, input int rw, input int wb, input int dn);
        return {1'(pcw), 1'(adr), 1'(irw), 1'(mr), 1'(mw), 2'(a), 2'(b), 4'(op),
                2'(ps), 1'(rw), 3'(wb), 1'(dn)};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.PCWrite, bus.AddrSrc, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.RegWrite, bus.WritebackSrc, bus.instr_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a negedge: drive inputs, check settled outputs, advance one clock.
    task automatic cyc(input string tag, input logic rdy, input logic [1:0] comp,
                       input logic [19:0] exp);
        bus.mem_ready = rdy;
        bus.Comp      = comp;
        #1;
        check(tag, 32'(obs()), 32'(exp));
        @(negedge clk);
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.Opcode = op;
        bus.Funct3 = f3;
        bus.Funct7 = f7;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_outs"}, 32'(obs()), 32'd0);
        check({tag, "_ill"}, 32'(bus.illegal), 32'd0);
        check({tag, "_berr"}, 32'(bus.bus_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [19:0] f_rdy, f_wait, dec, wb_alu;

    initial begin
        f_rdy  = ex(1, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        f_wait = ex(0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        dec    = ex(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        wb_alu = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        bus.Comp = 2'b00;
`ifdef MULDIV_EN
        bus.mdu_done = 1'b0;
`endif
        set_ir(7'b0110011, 3'd0, 7'd0);
        @(negedge clk);
        do_reset("rst0");

        // add, sub (R), addi with Funct7[5] set, srai
        cyc("add_f", 1, 0, f_rdy);
        cyc("add_d", 1, 0, dec);
        cyc("add_x", 1, 0, ex(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        cyc("add_wb", 1, 0, wb_alu);
        set_ir(7'b0110011, 3'd0, 7'b0100000);
        cyc("sub_f", 1, 0, f_rdy);
        cyc("sub_d", 1, 0, dec);
        cyc("sub_x", 1, 0, ex(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0));
        cyc("sub_wb", 1, 0, wb_alu);
        set_ir(7'b0010011, 3'd0, 7'b0100000);
        cyc("addi_f", 1, 0, f_rdy);
        cyc("addi_d", 1, 0, dec);
        cyc("addi_x", 1, 0, ex(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        cyc("addi_wb", 1, 0, wb_alu);
        set_ir(7'b0010011, 3'd5, 7'b0100000);
        cyc("srai_f", 1, 0, f_rdy);
        cyc("srai_d", 1, 0, dec);
        cyc("srai_x", 1, 0, ex(0, 0, 0, 0, 0, 2, 1, 7, 0, 0, 0, 0));
        cyc("srai_wb", 1, 0, wb_alu);

        // lw with three wait cycles in MEM_READ
        set_ir(7'b0000011, 3'd2, 7'd0);
        cyc("lw_f", 1, 0, f_rdy);
        cyc("lw_d", 1, 0, dec);
        cyc("lw_ma", 1, 0, ex(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw_mr_wait%0d", i), 0, 0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_mr_rdy", 1, 0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_wb", 1, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));

        // sw, zero-wait
        set_ir(7'b0100011, 3'd2, 7'd0);
        cyc("sw_f", 1, 0, f_rdy);
        cyc("sw_d", 1, 0, dec);
        cyc("sw_ma", 1, 0, ex(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        cyc("sw_mw", 1, 0, ex(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

        // branches: bne not taken / taken, blt taken, bgeu not taken
        set_ir(7'b1100011, 3'd1, 7'd0);
        cyc("bne0_f", 1, 0, f_rdy);
        cyc("bne0_d", 1, 0, dec);
        cyc("bne0_br", 1, 2'b01, ex(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 1));
        cyc("bne1_f", 1, 0, f_rdy);
        cyc("bne1_d", 1, 0, dec);
        cyc("bne1_br", 1, 2'b00, ex(1, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 1));
        set_ir(7'b1100011, 3'd4, 7'd0);
        cyc("blt_f", 1, 0, f_rdy);
        cyc("blt_d", 1, 0, dec);
        cyc("blt_br", 1, 2'b10, ex(1, 0, 0, 0, 0, 2, 0, 8, 1, 0, 0, 1));
        set_ir(7'b1100011, 3'd7, 7'd0);
        cyc("bgeu_f", 1, 0, f_rdy);
        cyc("bgeu_d", 1, 0, dec);
        cyc("bgeu_br", 1, 2'b10, ex(0, 0, 0, 0, 0, 2, 0, 9, 0, 0, 0, 1));

        // jal, jalr, lui, auipc
        set_ir(7'b1101111, 3'd0, 7'd0);
        cyc("jal_f", 1, 0, f_rdy);
        cyc("jal_d", 1, 0, dec);
        cyc("jal_j", 1, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1));
        set_ir(7'b1100111, 3'd0, 7'd0);
        cyc("jalr_f", 1, 0, f_rdy);
        cyc("jalr_d", 1, 0, dec);
        cyc("jalr_a", 1, 0, ex(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        cyc("jalr_wb", 1, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1));
        set_ir(7'b0110111, 3'd0, 7'd0);
        cyc("lui_f", 1, 0, f_rdy);
        cyc("lui_d", 1, 0, dec);
        cyc("lui_wb", 1, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1));
        set_ir(7'b0010111, 3'd0, 7'd0);
        cyc("auipc_f", 1, 0, f_rdy);
        cyc("auipc_d", 1, 0, dec);
        cyc("auipc_wb", 1, 0, wb_alu);

        // illegal opcode: sticky halt, cleared only by reset
        set_ir(7'b0000000, 3'd0, 7'd0);
        cyc("ill_f", 1, 0, f_rdy);
        cyc("ill_d", 1, 0, dec);
        for (int i = 0; i < 20; i++) cyc($sformatf("ill_halt%0d", i), 1, 0, 20'd0);
        check("ill_flag", 32'(bus.illegal), 32'd1);
        check("ill_berr", 32'(bus.bus_err), 32'd0);
        do_reset("rst_ill");
        cyc("ill_refetch", 1, 0, f_rdy);
        cyc("ill_redec", 1, 0, dec);
        cyc("ill_halt", 1, 0, 20'd0);
        do_reset("rst_ill2");

        // branch Funct3=2 is illegal
        set_ir(7'b1100011, 3'd2, 7'd0);
        cyc("bf3_f", 1, 0, f_rdy);
        cyc("bf3_d", 1, 0, dec);
        cyc("bf3_halt", 1, 0, 20'd0);
        check("bf3_flag", 32'(bus.illegal), 32'd1);
        do_reset("rst_bf3");
`ifndef MULDIV_EN
        set_ir(7'b0110011, 3'd0, 7'b0000001);
        cyc("mul_f", 1, 0, f_rdy);
        cyc("mul_d", 1, 0, dec);
        cyc("mul_halt", 1, 0, 20'd0);
        check("mul_flag", 32'(bus.illegal), 32'd1);
        do_reset("rst_mul");
`endif

        // watchdog: 16 waiting FETCH cycles then HALT with bus_err
        set_ir(7'b0110011, 3'd0, 7'd0);
        for (int i = 0; i < 16; i++) cyc($sformatf("to_wait%0d", i), 0, 0, f_wait);
        cyc("to_halt", 0, 0, 20'd0);
        check("to_berr", 32'(bus.bus_err), 32'd1);
        check("to_ill", 32'(bus.illegal), 32'd0);
        do_reset("rst_to");

        // mem_ready on the last allowed wait cycle completes the fetch
        for (int i = 0; i < 15; i++) cyc($sformatf("win_wait%0d", i), 0, 0, f_wait);
        cyc("win_f", 1, 0, f_rdy);
        cyc("win_d", 1, 0, dec);
        check("win_berr", 32'(bus.bus_err), 32'd0);
        cyc("win_x", 1, 0, ex(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        cyc("win_wb", 1, 0, wb_alu);

        // reset in the middle of MEM_WRITE
        set_ir(7'b0100011, 3'd2, 7'd0);
        cyc("rsw_f", 1, 0, f_rdy);
        cyc("rsw_d", 1, 0, dec);
        cyc("rsw_ma", 1, 0, ex(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        bus.mem_ready = 1'b0;
        #1;
        check("rsw_mw", 32'(obs()), 32'(ex(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        #2;
        rst = 1'b0;
        #1;
        check("rsw_rst_outs", 32'(obs()), 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        check("rsw_rst_rdy", 32'(obs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc("rsw_refetch", 1, 0, f_rdy);
        cyc("rsw_redec", 1, 0, dec);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
